ctrl_unit_16b: RTL and testbench
================================

CTRL_UNIT_16B -- requirements
Module: ctrl_unit_16b

Interface
REQ-001 SHALL have one clock and reset: clk (rising edge) and rst_n (synchronous, active-low); all other ports below.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 instr  input  16  instruction word; opcode instr[15:12], funct instr[1:0].
REQ-005 instr_valid  input  1  instr present; instr_ready  output  1  unit accepts instr.
REQ-006 check  input  1  branch-condition result from ALU_16b.
REQ-007 mem_ack  input  1  memory access complete.
REQ-008 ALUC  output  4  ALU operation select; ALUB  output  2  branch condition; Unsig  output  1  unsigned compare.
REQ-009 reg_we, mem_rd, mem_wr, pc_en, pc_sel, halted, illegal  output  1 each.

Function
REQ-010 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-011 FETCH: instr_ready=1; on instr_valid=1, latch instr into IR and go to DECODE; otherwise stay.
REQ-012 DECODE (1 cycle): register ALUC/ALUB/Unsig from IR; they hold their values through EXECUTE, MEM and WB.
REQ-013 Opcode map:
- 0x0 NOP -> ALUC=0000.
- 0x1 shift -> ALUC={01,funct}.
- 0x2 bitwise -> ALUC={10,funct}.
- 0x3 add/sub -> ALUC={110,funct[0]}.
- 0x4 ADDI, 0x5 LW, 0x6 SW -> ALUC=1100.
- 0x7 BR -> ALUC=1101, ALUB=IR[11:10], Unsig=IR[9].
- 0x8 JMP -> ALUC=0000.
- 0xF HALT.
- Others illegal (REQ-022).
REQ-014 ALUB=00 and Unsig=0 for every non-BR opcode.
REQ-015 EXECUTE transitions:
- 0x1-0x4 -> WB.
- 0x5, 0x6 -> MEM.
- 0x0, 0x7, 0x8 -> FETCH.
- 0xF -> HALT.
REQ-016 BR: sample check in EXECUTE; pc_sel=check; JMP: pc_sel=1; all else pc_sel=0.
REQ-017 pc_en SHALL pulse exactly one cycle on every transition into FETCH from EXECUTE, MEM or WB; pc_sel is valid in that same cycle.
REQ-018 MEM: mem_rd=1 (LW) or mem_wr=1 (SW) held until the cycle with mem_ack=1; then LW -> WB, SW -> FETCH; mem_ack is ignored outside MEM.
REQ-019 WB: reg_we=1 for exactly one cycle, then FETCH.
REQ-020 HALT: halted=1, instr_ready=0; remain until reset.
REQ-021 Latency: ALU ops 4 cycles FETCH-to-FETCH with instr_valid held; LW 5+N cycles, N = mem_ack wait cycles.

Reset
REQ-022 While rst_n=0 at a clk edge: state=FETCH, IR=0, ALUC=0000, ALUB=00, Unsig=0, all 1-bit outputs 0 except instr_ready (1 from the following cycle).
REQ-023 Reset mid-operation SHALL drop mem_rd/mem_wr/reg_we at that same edge, with no pc_en pulse.

Configuration
REQ-024 Macro CTRL_ILLEGAL_TRAP_EN:
- Defined: illegal opcode -> illegal=1 (sticky until reset), go to HALT.
- Undefined: illegal opcode executes as NOP and illegal is tied 0.

Verification
REQ-025 Reset: rst_n=0 for 2 cycles in MEM with mem_rd=1 -> mem_rd=0 next edge, state FETCH, ALUC=0000.
REQ-026 ALU: instr=0x3001 -> ALUC=1101 in EXECUTE; reg_we pulse in cycle 4; pc_en=1, pc_sel=0.
REQ-027 Shift: instr=0x1003 -> ALUC=0111, ALUB=00, Unsig=0.
REQ-028 BR: instr=0x7A00 with check=1 -> ALUB=10, Unsig=1, pc_sel=1 with pc_en; same instr with check=0 -> pc_sel=0.
REQ-029 LW: instr=0x5000, mem_ack after 3 cycles -> mem_rd high 3 cycles then low, then one reg_we pulse, then FETCH.
REQ-030 Illegal: instr=0xB000 -> with CTRL_ILLEGAL_TRAP_EN: illegal=1, halted=1, instr_ready=0; without it: FETCH after EXECUTE, illegal=0.

Source files
------------

// File: rtl/ctrl_unit_16b.sv
// ctrl_unit_16b: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB/HALT control unit; define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT
module ctrl_unit_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        check,
  input  logic        mem_ack,
  output logic [3:0]  ALUC,
  output logic [1:0]  ALUB,
  output logic        Unsig,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
  state_t      state;
  logic [15:0] ir;
  logic [3:0]  op;
  logic [3:0]  alu_d;
  logic        trap;
  assign op = ir[15:12];
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = op inside {[4'h9:4'hE]};
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    alu_d = op == 4'h1 ? {2'b01, ir[1:0]} :
            op == 4'h2 ? {2'b10, ir[1:0]} :
            op == 4'h3 ? {3'b110, ir[0]} :
            (op == 4'h4 || op == 4'h5 || op == 4'h6) ? 4'b1100 :
            op == 4'h7 ? 4'b1101 : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      ir          <= '0;
      ALUC        <= '0;
      ALUB        <= '0;
      Unsig       <= 1'b0;
      instr_ready <= 1'b1;
      reg_we      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      pc_en       <= 1'b0;
      pc_sel      <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      pc_en  <= 1'b0;
      pc_sel <= 1'b0;
      reg_we <= 1'b0;
      unique case (state)
        FETCH: if (instr_valid) begin
          ir          <= instr;
          instr_ready <= 1'b0;
          state       <= DECODE;
        end
        DECODE: begin
          ALUC  <= alu_d;
          ALUB  <= op == 4'h7 ? ir[11:10] : 2'b00;
          Unsig <= op == 4'h7 && ir[9];
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (op == 4'hF || trap) begin
            halted <= 1'b1;
            state  <= HALT;
            if (trap) illegal <= 1'b1;
          end else if (op >= 4'h1 && op <= 4'h4) begin
            reg_we <= 1'b1;
            state  <= WB;
          end else if (op == 4'h5 || op == 4'h6) begin
            mem_rd <= op == 4'h5;
            mem_wr <= op == 4'h6;
            state  <= MEM;
          end else begin
            // NOP, BR, JMP (and untrapped illegal opcodes) retire straight to FETCH
            pc_en       <= 1'b1;
            pc_sel      <= op == 4'h7 ? check : op == 4'h8;
            instr_ready <= 1'b1;
            state       <= FETCH;
          end
        end
        MEM: if (mem_ack) begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (op == 4'h5) begin
            reg_we <= 1'b1;
            state  <= WB;
          end else begin
            pc_en       <= 1'b1;
            instr_ready <= 1'b1;
            state       <= FETCH;
          end
        end
        WB: begin
          pc_en       <= 1'b1;
          instr_ready <= 1'b1;
          state       <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_unit_16b.sv
// tb_ctrl_unit_16b: scoreboard bench; retirement expectations are queued at issue and popped on each pc_en pulse
module tb_ctrl_unit_16b;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid, instr_ready, check, mem_ack;
  logic [3:0]  ALUC;
  logic [1:0]  ALUB;
  logic        Unsig, reg_we, mem_rd, mem_wr, pc_en, pc_sel, halted, illegal;
  typedef struct {
    logic [15:0] ins;
    logic        c;
    int          ack;
    logic [3:0]  aluc;
    logic [1:0]  alub;
    logic        u;
    logic        ps;
    int          lat;
    int          we;
    int          mc;
    int          t0;
  } row_t;
  row_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  ctrl_unit_16b dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .check(check), .mem_ack(mem_ack),
    .ALUC(ALUC), .ALUB(ALUB), .Unsig(Unsig), .reg_we(reg_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_en(pc_en), .pc_sel(pc_sel),
    .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic row_t mk(logic [15:0] ins, logic c, int ack, logic [3:0] aluc,
                              logic [1:0] alub, logic u, logic ps, int lat, int we, int mc);
    row_t r;
    r.ins = ins; r.c = c; r.ack = ack; r.aluc = aluc; r.alub = alub;
    r.u = u; r.ps = ps; r.lat = lat; r.we = we; r.mc = mc; r.t0 = 0;
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && pc_en) begin
      if (sb.size() == 0) chk("spurious_pc_en", 1, 0);
      else begin
        row_t e;
        e = sb.pop_front();
        chk($sformatf("pc_sel_%h", e.ins), pc_sel, e.ps);
        chk($sformatf("aluc_%h", e.ins), ALUC, e.aluc);
        chk($sformatf("alub_%h", e.ins), ALUB, e.alub);
        chk($sformatf("unsig_%h", e.ins), Unsig, e.u);
        chk($sformatf("latency_%h", e.ins), cyc - e.t0, e.lat);
      end
    end
  end
  task automatic wait_ready();
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
  endtask
  task automatic issue(input logic [15:0] ins);
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask
  task automatic run(input row_t r);
    int we_n, mc_n;
    bit done;
    wait_ready();
    instr = r.ins;
    instr_valid = 1'b1;
    check = r.c;
    mem_ack = r.ack == 0;
    r.t0 = cyc;
    sb.push_back(r);
    @(negedge clk);
    instr_valid = 1'b0;
    we_n = 0; mc_n = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (reg_we) we_n++;
      if (mem_rd || mem_wr) mc_n++;
      if (r.ack != 0) mem_ack = (mem_rd || mem_wr) && mc_n == r.ack;
      if (pc_en) done = 1;
      else @(negedge clk);
    end
    chk($sformatf("retired_%h", r.ins), done, 1);
    chk($sformatf("reg_we_pulses_%h", r.ins), we_n, r.we);
    chk($sformatf("mem_cycles_%h", r.ins), mc_n, r.mc);
    chk($sformatf("ready_%h", r.ins), instr_ready, 1);
    mem_ack = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_halt();
    for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; check = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_aluc", ALUC, 0);
    chk("rst_alub_unsig", {ALUB, Unsig}, 0);
    chk("rst_strobes", {reg_we, mem_rd, mem_wr, pc_en, pc_sel}, 0);
    chk("rst_flags", {halted, illegal}, 0);
    rst_n = 1'b1;
    issue(16'h5000);
    for (int i = 0; i < 10 && !mem_rd; i++) @(negedge clk);
    chk("lw_mem_rd_before_reset", mem_rd, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_aluc", ALUC, 0);
    chk("midrst_pc_en", pc_en, 0);
    chk("midrst_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(16'h3001, 1, 0, 4'hD, 2'b00, 0, 0, 4, 1, 0));
    run(mk(16'h1003, 1, 0, 4'h7, 2'b00, 0, 0, 4, 1, 0));
    run(mk(16'h7A00, 1, 0, 4'hD, 2'b10, 1, 1, 3, 0, 0));
    run(mk(16'h7A00, 0, 0, 4'hD, 2'b10, 1, 0, 3, 0, 0));
    run(mk(16'h5000, 0, 3, 4'hC, 2'b00, 0, 0, 7, 1, 3));
    run(mk(16'h6000, 0, 1, 4'hC, 2'b00, 0, 0, 4, 0, 1));
    run(mk(16'h5000, 0, 1, 4'hC, 2'b00, 0, 0, 5, 1, 1));
    run(mk(16'h8000, 0, 0, 4'h0, 2'b00, 0, 1, 3, 0, 0));
    run(mk(16'h2002, 0, 0, 4'hA, 2'b00, 0, 0, 4, 1, 0));
    run(mk(16'h0000, 1, 0, 4'h0, 2'b00, 0, 0, 3, 0, 0));
    run(mk(16'h4000, 0, 0, 4'hC, 2'b00, 0, 0, 4, 1, 0));
    run(mk(16'h7500, 1, 0, 4'hD, 2'b01, 0, 1, 3, 0, 0));
    run(mk(16'h3000, 0, 0, 4'hC, 2'b00, 0, 0, 4, 1, 0));
`ifdef CTRL_ILLEGAL_TRAP_EN
    issue(16'hB000);
    wait_halt();
    chk("illegal_flag", illegal, 1);
    chk("illegal_halted", halted, 1);
    chk("illegal_ready", instr_ready, 0);
    do_reset();
    chk("illegal_cleared", illegal, 0);
`else
    run(mk(16'hB000, 0, 0, 4'h0, 2'b00, 0, 0, 3, 0, 0));
    chk("illegal_tied_low", illegal, 0);
`endif
    issue(16'hF000);
    wait_halt();
    chk("halt_halted", halted, 1);
    chk("halt_ready", instr_ready, 0);
    instr_valid = 1'b1;
    repeat (5) @(negedge clk);
    instr_valid = 1'b0;
    chk("halt_stays", {halted, instr_ready}, 2'b10);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
